// File: rtl/mem_ctrl_m1_pkg.sv
// rtl/mem_ctrl_m1_pkg.sv - request/pending entry types, mode encoding and load formatting
package mem_ctrl_m1_pkg;

    localparam logic [1:0] MODE_READ  = 2'd0;
    localparam logic [1:0] MODE_WRITE = 2'd1;
    localparam int         MODE_FENCE_BIT = 1;

    typedef struct packed {
        logic [15:0] data;
        logic [14:0] address;
        logic [1:0]  mask;
        logic [1:0]  fnc_type;
        logic [1:0]  mode;
        logic [3:0]  wb_dest;
    } req_entry_t;

    typedef struct packed {
        logic        is_read;
        logic [3:0]  wb_dest;
        logic [1:0]  mask;
        logic [1:0]  fnc_type;
    } pend_entry_t;

    typedef enum logic {
        ST_RUN         = 1'b0,
        ST_FENCE_DRAIN = 1'b1
    } ctrl_state_t;

    // Memory lane order -> register order; byte loads pick the enabled lane and extend.
    function automatic logic [15:0] format_load(input logic [15:0] rdata,
                                                input logic [1:0]  mask,
                                                input logic [1:0]  fnc);
        logic [7:0] w_byte;
        w_byte = (mask == 2'b10) ? rdata[15:8] : rdata[7:0];
        if (fnc[0])
            format_load = {rdata[7:0], rdata[15:8]};
        else if (fnc[1])
            format_load = {8'h00, w_byte};
        else
            format_load = {{8{w_byte[7]}}, w_byte};
    endfunction

endpackage

// File: rtl/mem_ctrl_m1_if.sv
// rtl/mem_ctrl_m1_if.sv - in-order variable-latency memory bus
interface mem_ctrl_m1_if;
    logic        bus_req;
    logic        bus_we;
    logic [14:0] bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [15:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_ctrl_fifo_m1.sv
// rtl/mem_ctrl_fifo_m1.sv - synchronous FIFO with occupancy count
module mem_ctrl_fifo_m1 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     async_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign o_count = r_wptr - r_rptr;
    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer advance; overflowing pushes and underflowing pops are dropped.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end
endmodule

// File: rtl/mem_ctrl_m1.sv
// rtl/mem_ctrl_m1.sv - M1 LSU memory controller top (option: MEM_CTRL_RD_REG_EN)
module mem_ctrl_m1
    import mem_ctrl_m1_pkg::*;
#(
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        async_rst_n,
    input  logic        clk_en,
    input  logic [14:0] req_address,
    input  logic [1:0]  req_mask,
    input  logic [1:0]  req_fnc_type,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_mode,
    input  logic        req_enable,
    input  logic [3:0]  req_wb_dest,
    input  logic        req_input_ready,
    output logic        mem_available,
    output logic        mem_idle,
    output logic [15:0] rd_data,
    output logic [3:0]  rd_wb_dest,
    output logic        rd_ack,
    mem_ctrl_m1_if.master bus
);
    localparam int QAW = $clog2(REQ_DEPTH);
    localparam int OAW = $clog2(MAX_OUTSTANDING);

    req_entry_t   w_req_in;
    req_entry_t   w_head;
    pend_entry_t  w_pend_in;
    pend_entry_t  w_pend_head;
    logic [QAW:0] w_q_count;
    logic [QAW:0] w_q_free;
    logic         w_q_full;
    logic         w_q_empty;
    logic [OAW:0] w_o_count;
    logic         w_o_full;
    logic         w_o_empty;
    logic         w_accept;
    logic         w_q_pop;
    logic         w_grant;
    logic         w_fence_pop;
    logic         w_head_fence;
    logic         w_head_mem;
    logic         w_rsp;
    logic         w_ack;
    logic         w_base_idle;
    logic [15:0]  w_ld_data;
    ctrl_state_t  r_state;
    ctrl_state_t  w_state_nxt;

    assign w_accept = clk_en && req_enable && req_input_ready;
    assign w_req_in = '{data: req_data, address: req_address, mask: req_mask,
                        fnc_type: req_fnc_type, mode: req_mode, wb_dest: req_wb_dest};

    mem_ctrl_fifo_m1 #(.WIDTH($bits(req_entry_t)), .DEPTH(REQ_DEPTH)) u_req_q (
        .clk(clk), .async_rst_n(async_rst_n),
        .i_push(w_accept), .i_push_data(w_req_in), .i_pop(w_q_pop),
        .o_head(w_head), .o_count(w_q_count), .o_full(w_q_full), .o_empty(w_q_empty)
    );

    assign w_head_fence = !w_q_empty && w_head.mode[MODE_FENCE_BIT];
    assign w_head_mem   = !w_q_empty && !w_head.mode[MODE_FENCE_BIT];
    // A fence leaves the queue only once every earlier transfer has been answered.
    assign w_fence_pop  = clk_en && w_head_fence && (w_o_count == '0);
    assign w_grant      = bus.bus_req && bus.bus_gnt;
    assign w_q_pop      = w_grant || w_fence_pop;

    assign w_pend_in = '{is_read: (w_head.mode == MODE_READ), wb_dest: w_head.wb_dest,
                         mask: w_head.mask, fnc_type: w_head.fnc_type};

    mem_ctrl_fifo_m1 #(.WIDTH($bits(pend_entry_t)), .DEPTH(MAX_OUTSTANDING)) u_out_q (
        .clk(clk), .async_rst_n(async_rst_n),
        .i_push(w_grant), .i_push_data(w_pend_in), .i_pop(w_rsp),
        .o_head(w_pend_head), .o_count(w_o_count), .o_full(w_o_full), .o_empty(w_o_empty)
    );

    assign w_rsp = clk_en && bus.bus_rvalid && !w_o_empty;
    assign w_ack = w_rsp && w_pend_head.is_read;
    assign w_ld_data = format_load(bus.bus_rdata, w_pend_head.mask, w_pend_head.fnc_type);

    // Two free slots leave room for the request the LSU may already be presenting.
    assign w_q_free      = (QAW+1)'(REQ_DEPTH) - w_q_count;
    assign mem_available = (w_q_free >= (QAW+1)'(2));
    assign w_base_idle   = w_q_empty && (w_o_count == '0) && (r_state == ST_RUN);

    assign bus.bus_we    = (w_head.mode == MODE_WRITE);
    assign bus.bus_addr  = w_head.address;
    assign bus.bus_be    = w_head.mask;
    assign bus.bus_wdata = w_head.data;

    // FSM state register; frozen while the clock enable is low.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)
            r_state <= ST_RUN;
        else if (clk_en)
            r_state <= w_state_nxt;
    end

    // FSM next state: a fence with transfers in flight parks the issue path until they drain.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:         if (w_head_fence && (w_o_count != '0)) w_state_nxt = ST_FENCE_DRAIN;
            ST_FENCE_DRAIN: if (w_o_count == '0)                   w_state_nxt = ST_RUN;
            default:                                               w_state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: request the bus for a load/store head when a pending slot is free.
    always_comb begin
        bus.bus_req = 1'b0;
        if ((r_state == ST_RUN) && w_head_mem && !w_o_full)
            bus.bus_req = clk_en;
    end

`ifdef MEM_CTRL_RD_REG_EN
    logic        r_rd_ack;
    logic [15:0] r_rd_data;
    logic [3:0]  r_rd_wb_dest;

    // Registered writeback stage: one extra cycle of load latency.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_rd_ack     <= 1'b0;
            r_rd_data    <= '0;
            r_rd_wb_dest <= '0;
        end else if (clk_en) begin
            r_rd_ack     <= w_ack;
            r_rd_data    <= w_ack ? w_ld_data : '0;
            r_rd_wb_dest <= w_ack ? w_pend_head.wb_dest : '0;
        end
    end

    assign rd_ack     = r_rd_ack;
    assign rd_data    = r_rd_data;
    assign rd_wb_dest = r_rd_wb_dest;
    assign mem_idle   = w_base_idle && !r_rd_ack;
`else
    assign rd_ack     = w_ack;
    assign rd_data    = w_ack ? w_ld_data : '0;
    assign rd_wb_dest = w_ack ? w_pend_head.wb_dest : '0;
    assign mem_idle   = w_base_idle;
`endif

    a_no_queue_overflow: assert property (@(posedge clk) disable iff (!async_rst_n)
        !(w_accept && w_q_full));
    a_no_orphan_response: assert property (@(posedge clk) disable iff (!async_rst_n)
        !(clk_en && bus.bus_rvalid && w_o_empty));
endmodule

// File: tb/tb_mem_ctrl_m1.sv
// tb/tb_mem_ctrl_m1.sv - self-checking bench for mem_ctrl_m1
module tb_mem_ctrl_m1;
    import mem_ctrl_m1_pkg::*;

    localparam int REQ_DEPTH = 4;
    localparam int MAX_OUT   = 4;

    logic        clk = 1'b0;
    logic        async_rst_n, clk_en;
    logic [14:0] req_address;
    logic [1:0]  req_mask, req_fnc_type, req_mode;
    logic [15:0] req_data;
    logic        req_enable, req_input_ready;
    logic [3:0]  req_wb_dest;
    logic        mem_available, mem_idle, rd_ack;
    logic [15:0] rd_data;
    logic [3:0]  rd_wb_dest;

    mem_ctrl_m1_if bus_if();

    mem_ctrl_m1 dut (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
        .req_address(req_address), .req_mask(req_mask), .req_fnc_type(req_fnc_type),
        .req_data(req_data), .req_mode(req_mode), .req_enable(req_enable),
        .req_wb_dest(req_wb_dest), .req_input_ready(req_input_ready),
        .mem_available(mem_available), .mem_idle(mem_idle),
        .rd_data(rd_data), .rd_wb_dest(rd_wb_dest), .rd_ack(rd_ack),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [14:0] addr;
        logic [1:0]  mask;
        logic [1:0]  fnc;
        logic [15:0] data;
        logic [3:0]  dest;
    } mreq_t;

    typedef struct {
        mreq_t       r;
        int          due;
        logic [15:0] rdata;
    } mpend_t;

    typedef struct {
        logic [15:0] rdata;
        logic [1:0]  mask;
        logic [1:0]  fnc;
        logic [3:0]  dest;
        logic [15:0] exp;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    mreq_t  mq[$];
    mpend_t pend[$];
    mreq_t  n_req;
    logic   n_en, n_rdy, n_ce, n_gnt, n_rv;
    logic [15:0] n_rdata;
    bit     auto_bus;
    logic   last_avail;
    logic        prev_ack;
    logic [15:0] prev_data;
    logic [3:0]  prev_dest;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Load result from byte arithmetic: word swaps lanes, byte selects a lane and extends.
    function automatic logic [15:0] model_rd(input logic [15:0] rd, input logic [1:0] mask,
                                             input logic [1:0] fnc);
        int hi, lo, b;
        hi = int'(rd) / 256;
        lo = int'(rd) % 256;
        if (fnc[0]) return 16'(lo * 256 + hi);
        b = (mask == 2'b10) ? hi : lo;
        if (!fnc[1] && b >= 128) b -= 256;
        return 16'(b);
    endfunction

    // One clock: drive at the falling edge, check against the model, then advance the model.
    task automatic step();
        int     pend_sz, mq_sz;
        logic   exp_req, exp_idle, e_ack, head_fence;
        logic [15:0] e_data;
        logic [3:0]  e_dest;
        mpend_t p;
        @(negedge clk);
        clk_en = n_ce; req_enable = n_en; req_input_ready = n_rdy;
        req_mode = n_req.mode; req_address = n_req.addr; req_mask = n_req.mask;
        req_fnc_type = n_req.fnc; req_data = n_req.data; req_wb_dest = n_req.dest;
        if (auto_bus) begin
            bus_if.bus_gnt    = ($urandom_range(0, 3) != 0);
            bus_if.bus_rvalid = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
            if (bus_if.bus_rvalid && pend[0].due > cyc) bus_if.bus_rvalid = 1'b0;
            bus_if.bus_rdata  = bus_if.bus_rvalid ? pend[0].rdata : 16'($urandom);
        end else begin
            bus_if.bus_gnt    = n_gnt;
            bus_if.bus_rvalid = n_rv && (pend.size() > 0);
            bus_if.bus_rdata  = n_rdata;
        end
        #1;
        pend_sz = pend.size();
        mq_sz   = mq.size();
        head_fence = 1'b0;
        exp_req    = 1'b0;
        if (mq_sz > 0) begin
            head_fence = mq[0].mode[1];
            exp_req    = n_ce && !head_fence && (pend_sz < MAX_OUT);
        end
        exp_idle = (mq_sz == 0) && (pend_sz == 0);
`ifdef MEM_CTRL_RD_REG_EN
        exp_idle = exp_idle && !prev_ack;
`endif
        chk("mem_available", mem_available, (REQ_DEPTH - mq_sz) >= 2);
        chk("mem_idle", mem_idle, exp_idle);
        chk("bus_req", bus_if.bus_req, exp_req);
        if (exp_req) begin
            chk("bus_we", bus_if.bus_we, mq[0].mode == MODE_WRITE);
            chk("bus_addr", bus_if.bus_addr, mq[0].addr);
            chk("bus_be", bus_if.bus_be, mq[0].mask);
            chk("bus_wdata", bus_if.bus_wdata, mq[0].data);
        end
        e_ack = 1'b0; e_data = '0; e_dest = '0;
        if (n_ce && bus_if.bus_rvalid && pend_sz > 0) begin
            p = pend.pop_front();
            if (p.r.mode == MODE_READ) begin
                e_ack  = 1'b1;
                e_data = model_rd(bus_if.bus_rdata, p.r.mask, p.r.fnc);
                e_dest = p.r.dest;
            end
        end
`ifdef MEM_CTRL_RD_REG_EN
        chk("rd_ack", rd_ack, prev_ack);
        chk("rd_data", rd_data, prev_data);
        chk("rd_wb_dest", rd_wb_dest, prev_dest);
        if (n_ce) begin prev_ack = e_ack; prev_data = e_data; prev_dest = e_dest; end
`else
        chk("rd_ack", rd_ack, e_ack);
        chk("rd_data", rd_data, e_data);
        chk("rd_wb_dest", rd_wb_dest, e_dest);
`endif
        if (exp_req && bus_if.bus_gnt) begin
            p.r     = mq.pop_front();
            p.due   = cyc + int'($urandom_range(1, 4));
            p.rdata = 16'($urandom);
            pend.push_back(p);
        end else if (n_ce && head_fence && pend_sz == 0) begin
            void'(mq.pop_front());
        end
        if (n_ce && n_en && n_rdy && mq_sz < REQ_DEPTH) mq.push_back(n_req);
        last_avail = mem_available;
        cyc++;
    endtask

    task automatic set_req(input logic [1:0] mode, input logic [14:0] addr, input logic [1:0] mask,
                           input logic [1:0] fnc, input logic [15:0] data, input logic [3:0] dest);
        n_req.mode = mode; n_req.addr = addr; n_req.mask = mask;
        n_req.fnc = fnc; n_req.data = data; n_req.dest = dest;
    endtask

    task automatic drain();
        n_en = 1'b0; n_gnt = 1'b1; n_rv = 1'b1; n_ce = 1'b1;
        for (int k = 0; k < 60 && (mq.size() + pend.size()) > 0; k++) step();
        chk("drain_complete", mq.size() + pend.size(), 0);
        n_gnt = 1'b0; n_rv = 1'b0;
        step();
        step();
        chk("idle_after_drain", mem_idle, 1'b1);
    endtask

    task automatic do_load(input vec_t v);
        set_req(MODE_READ, 15'h0010, v.mask, v.fnc, 16'h0, v.dest);
        n_en = 1'b1; n_gnt = 1'b0; step();
        n_en = 1'b0; n_gnt = 1'b1; step();
        chk("load_bus_addr", bus_if.bus_addr, 15'h0010);
        n_gnt = 1'b0; step(); step();
        n_rv = 1'b1; n_rdata = v.rdata; step();
        n_rv = 1'b0;
`ifdef MEM_CTRL_RD_REG_EN
        step();
`endif
        chk("vec_rd_ack", rd_ack, 1'b1);
        chk("vec_rd_data", rd_data, v.exp);
        chk("vec_rd_wb_dest", rd_wb_dest, v.dest);
    endtask

    task automatic rand_req();
        int r;
        r = int'($urandom_range(0, 19));
        n_req.addr = 15'($urandom); n_req.dest = 4'($urandom); n_req.data = 16'($urandom);
        if (r < 9) begin
            n_req.mode = MODE_READ;
            if ($urandom_range(0, 1) == 1) begin
                n_req.mask = 2'b11; n_req.fnc = {1'($urandom), 1'b1};
            end else begin
                n_req.mask = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
                n_req.fnc  = {1'($urandom), 1'b0};
            end
        end else if (r < 17) begin
            n_req.mode = MODE_WRITE; n_req.mask = 2'($urandom_range(1, 3)); n_req.fnc = 2'b00;
        end else begin
            n_req.mode = 2'($urandom_range(2, 3)); n_req.mask = 2'b00; n_req.fnc = 2'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[7];
        tab[0] = '{16'h3412, 2'b11, 2'b01, 4'd5, 16'h1234};
        tab[1] = '{16'h80FF, 2'b10, 2'b00, 4'd1, 16'hFF80};
        tab[2] = '{16'h80FF, 2'b01, 2'b10, 4'd2, 16'h00FF};
        tab[3] = '{16'h80FF, 2'b01, 2'b00, 4'd3, 16'hFFFF};
        tab[4] = '{16'h80FF, 2'b10, 2'b10, 4'd4, 16'h0080};
        tab[5] = '{16'h7F01, 2'b10, 2'b00, 4'd6, 16'h007F};
        tab[6] = '{16'hABCD, 2'b11, 2'b11, 4'd7, 16'hCDAB};

        async_rst_n = 1'b0; clk_en = 1'b0; req_enable = 1'b0; req_input_ready = 1'b0;
        req_address = '0; req_mask = '0; req_fnc_type = '0; req_data = '0; req_mode = '0;
        req_wb_dest = '0;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
        set_req(MODE_READ, 15'h0, 2'b11, 2'b01, 16'h0, 4'h0);
        n_en = 1'b0; n_rdy = 1'b1; n_ce = 1'b1; n_gnt = 1'b0; n_rv = 1'b0; n_rdata = '0;
        auto_bus = 1'b0; last_avail = 1'b1;
        prev_ack = 1'b0; prev_data = '0; prev_dest = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_bus_req", bus_if.bus_req, 1'b0);
        chk("reset_rd_ack", rd_ack, 1'b0);
        chk("reset_rd_data", rd_data, 16'h0);
        chk("reset_rd_wb_dest", rd_wb_dest, 4'h0);
        @(negedge clk);
        async_rst_n = 1'b1;
        step();
        chk("post_reset_idle", mem_idle, 1'b1);
        chk("post_reset_available", mem_available, 1'b1);

        for (int i = 0; i < 7; i++) do_load(tab[i]);

        // Back-to-back accepts with no grant: availability falls at one free slot.
        n_gnt = 1'b0; n_rdy = 1'b1; n_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(MODE_WRITE, 15'(16'h0100 + i), 2'b11, 2'b00, 16'(16'hA000 + i), 4'h0);
            step();
        end
        n_rdy = 1'b0;
        step();
        chk("available_one_free", mem_available, 1'b0);
        step();
        chk("held_not_enqueued", mem_available, 1'b0);
        n_rdy = 1'b1;
        drain();

        // Fence behind two slow stores, then a load.
        n_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_en = (i < 4); n_rv = (i == 6 || i == 7); n_rdata = 16'h5555;
            case (i)
                0: set_req(MODE_WRITE, 15'h0100, 2'b11, 2'b00, 16'hAAAA, 4'h0);
                1: set_req(MODE_WRITE, 15'h0101, 2'b10, 2'b00, 16'hBBBB, 4'h0);
                2: set_req(2'd2, 15'h0000, 2'b00, 2'b01, 16'h0000, 4'h0);
                3: set_req(MODE_READ, 15'h0200, 2'b11, 2'b01, 16'h0000, 4'd9);
                default: ;
            endcase
            step();
            if (i >= 3 && i <= 8) begin
                chk("fence_no_bus_req", bus_if.bus_req, 1'b0);
                chk("fence_not_idle", mem_idle, 1'b0);
            end
            if (i == 9) begin
                chk("post_fence_req", bus_if.bus_req, 1'b1);
                chk("post_fence_addr", bus_if.bus_addr, 15'h0200);
            end
        end
        drain();

        // Outstanding FIFO full, then a grant and response in the same cycle.
        n_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_en = (i < 5); n_rv = (i == 7 || i == 8); n_rdata = 16'h1357;
            set_req(MODE_READ, 15'(16'h0300 + i), 2'b11, 2'b01, 16'h0, 4'(i + 1));
            step();
            if (i == 5 || i == 7) chk("outstanding_full_no_req", bus_if.bus_req, 1'b0);
            if (i == 8) chk("req_after_free", bus_if.bus_req, 1'b1);
`ifndef MEM_CTRL_RD_REG_EN
            if (i == 7) chk("order_dest_first", rd_wb_dest, 4'd1);
            if (i == 8) chk("order_dest_second", rd_wb_dest, 4'd2);
`endif
        end
        drain();

        // Asynchronous reset while a load response is on the bus.
        n_gnt = 1'b0; n_rv = 1'b0; n_en = 1'b1;
        set_req(MODE_READ, 15'h0400, 2'b11, 2'b01, 16'h0, 4'd11); step();
        set_req(MODE_READ, 15'h0401, 2'b11, 2'b01, 16'h0, 4'd12); n_gnt = 1'b1; step();
        n_en = 1'b0; n_gnt = 1'b0; n_rv = 1'b1; n_rdata = 16'h00FF; step();
        #2;
        async_rst_n = 1'b0;
        #1;
        chk("async_reset_bus_req", bus_if.bus_req, 1'b0);
        chk("async_reset_rd_ack", rd_ack, 1'b0);
        chk("async_reset_rd_data", rd_data, 16'h0);
        chk("async_reset_rd_wb_dest", rd_wb_dest, 4'h0);
        mq.delete(); pend.delete();
        prev_ack = 1'b0; prev_data = '0; prev_dest = '0;
        n_rv = 1'b0; bus_if.bus_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        async_rst_n = 1'b1;
        step();
        chk("release_idle", mem_idle, 1'b1);
        chk("release_available", mem_available, 1'b1);

        // Random traffic against the reference model.
        auto_bus = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            n_ce  = ($urandom_range(0, 9) != 0);
            n_rdy = ($urandom_range(0, 4) != 0);
            n_en  = last_avail && ($urandom_range(0, 1) == 1);
            rand_req();
            step();
        end
        auto_bus = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
